// File: rtl/slime_damage_gen.sv
// Per-frame slime/player hitbox scan that reports a saturated hit count as a 1-cycle pulse.
// Optional report holdoff is enabled by defining DAMAGE_HOLDOFF_EN.
module slime_damage_gen #(
  parameter int NUM_SLIME      = 4,
  parameter int COORD_W        = 10,
  parameter int BOX_W          = 32,
  parameter int BOX_H          = 32,
  parameter int HOLDOFF_FRAMES = 64,
  localparam int IDX_W = (NUM_SLIME > 1) ? $clog2(NUM_SLIME) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] player_x,
  input  logic [COORD_W-1:0] player_y,
  output logic [IDX_W-1:0]   slime_idx,
  input  logic [COORD_W-1:0] slime_x,
  input  logic [COORD_W-1:0] slime_y,
  input  logic               slime_alive,
  output logic [1:0]         slim_damage,
  output logic [IDX_W-1:0]   hit_idx,
  output logic               busy
);

  if (NUM_SLIME < 1 || HOLDOFF_FRAMES < 0 || HOLDOFF_FRAMES > 255) begin : g_bad_cfg
    $error("slime_damage_gen: NUM_SLIME must be >=1, HOLDOFF_FRAMES must fit 8 bits");
  end

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CMP,
    REPORT
  } state_t;

  localparam logic [COORD_W:0] BOX_W_C = (COORD_W+1)'(BOX_W);
  localparam logic [COORD_W:0] BOX_H_C = (COORD_W+1)'(BOX_H);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLIME - 1);

  state_t               r_state;
  state_t               w_next;
  logic [COORD_W-1:0]   r_px;
  logic [COORD_W-1:0]   r_py;
  logic [IDX_W-1:0]     r_idx;
  logic [1:0]           r_cnt;
  logic                 r_found;
  logic [IDX_W-1:0]     r_pend;
  logic [1:0]           r_damage;
  logic [IDX_W-1:0]     r_hit_idx;
  logic                 r_busy;
  logic                 w_supp;

  logic signed [COORD_W:0] w_dx;
  logic signed [COORD_W:0] w_dy;
  logic [COORD_W:0]        w_adx;
  logic [COORD_W:0]        w_ady;
  logic                    w_hit;
  logic                    w_last;

  // Signed distance in one extra bit so coordinates never wrap around the screen.
  always_comb begin
    w_dx  = $signed({1'b0, slime_x}) - $signed({1'b0, r_px});
    w_dy  = $signed({1'b0, slime_y}) - $signed({1'b0, r_py});
    w_adx = w_dx[COORD_W] ? $unsigned(-w_dx) : $unsigned(w_dx);
    w_ady = w_dy[COORD_W] ? $unsigned(-w_dy) : $unsigned(w_dy);
    w_hit = slime_alive && (w_adx < BOX_W_C) && (w_ady < BOX_H_C);
    w_last = (r_idx == LAST_IDX);
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (frame_tick) w_next = FETCH;
      FETCH:   w_next = CMP;
      CMP:     w_next = w_last ? REPORT : FETCH;
      REPORT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_px      <= '0;
      r_py      <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_found   <= 1'b0;
      r_pend    <= '0;
      r_damage  <= '0;
      r_hit_idx <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_damage <= '0;
      unique case (r_state)
        IDLE: begin
          if (frame_tick) begin
            r_px    <= player_x;
            r_py    <= player_y;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_found <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        FETCH: begin
        end
        CMP: begin
          if (w_hit) begin
            if (r_cnt != 2'd3) r_cnt <= r_cnt + 2'd1;
            if (!r_found) begin
              r_found <= 1'b1;
              r_pend  <= r_idx;
            end
          end
          if (!w_last) r_idx <= r_idx + 1'b1;
        end
        REPORT: begin
          r_damage <= w_supp ? 2'd0 : r_cnt;
          if (r_cnt != 2'd0) r_hit_idx <= r_pend;
          r_busy <= 1'b0;
          r_idx  <= '0;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef DAMAGE_HOLDOFF_EN
  logic [7:0] r_hold;
  logic       r_supp;

  // Suppression is decided from the counter as seen when the scan starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold <= '0;
      r_supp <= 1'b0;
    end else begin
      if (r_state == REPORT && r_cnt != 2'd0 && !r_supp)
        r_hold <= 8'(HOLDOFF_FRAMES);
      else if (frame_tick && r_hold != 8'd0)
        r_hold <= r_hold - 8'd1;
      if (r_state == IDLE && frame_tick)
        r_supp <= (r_hold != 8'd0);
    end
  end

  assign w_supp = r_supp;
`else
  assign w_supp = 1'b0;
`endif

  assign slime_idx   = r_idx;
  assign slim_damage = r_damage;
  assign hit_idx     = r_hit_idx;
  assign busy        = r_busy;

endmodule

// File: tb/tb_slime_damage_gen.sv
// Randomized self-checking bench for slime_damage_gen against a behavioural hit-count model.
// Holdoff expectations follow DAMAGE_HOLDOFF_EN when the bench is built with it.
module tb_slime_damage_gen;

  localparam int N    = 4;
  localparam int CW   = 10;
  localparam int HOLD = 64;

  logic          clk;
  logic          reset;
  logic          frame_tick;
  logic [CW-1:0] player_x;
  logic [CW-1:0] player_y;
  logic [1:0]    slime_idx;
  logic [CW-1:0] slime_x;
  logic [CW-1:0] slime_y;
  logic          slime_alive;
  logic [1:0]    slim_damage;
  logic [1:0]    hit_idx;
  logic          busy;

  logic [CW-1:0] mx [N];
  logic [CW-1:0] my [N];
  logic          ma [N];

  int n_checks;
  int n_fail;
  int exp_hidx;
  int hold_m;

  slime_damage_gen #(
    .NUM_SLIME(N),
    .COORD_W(CW),
    .BOX_W(32),
    .BOX_H(32),
    .HOLDOFF_FRAMES(HOLD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_tick(frame_tick),
    .player_x(player_x),
    .player_y(player_y),
    .slime_idx(slime_idx),
    .slime_x(slime_x),
    .slime_y(slime_y),
    .slime_alive(slime_alive),
    .slim_damage(slim_damage),
    .hit_idx(hit_idx),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slime position store with one cycle of read latency.
  always @(posedge clk) begin
    slime_x     <= mx[slime_idx];
    slime_y     <= my[slime_idx];
    slime_alive <= ma[slime_idx];
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model(input int px, input int py,
                       output int hits, output int first);
    hits  = 0;
    first = -1;
    for (int i = 0; i < N; i++) begin
      if (ma[i] && iabs(int'(mx[i]) - px) < 32 &&
          iabs(int'(my[i]) - py) < 32) begin
        hits++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic set_slot(input int i, input int x, input int y, input bit a);
    mx[i] = CW'(x);
    my[i] = CW'(y);
    ma[i] = a;
  endtask

  task automatic kill_all();
    for (int i = 0; i < N; i++) set_slot(i, 0, 0, 1'b0);
  endtask

  // late: loop index at which a second tick is raised (-1 for none).
  task automatic run_scan(input string tag, input int px, input int py,
                          input int late, input bit scramble);
    int hits, first, exp_dmg, busy_cnt, npulse, pulse_at, got;
    bit supp;
    model(px, py, hits, first);
    exp_dmg = (hits > 3) ? 3 : hits;
    supp = (hold_m != 0);
    if (hold_m > 0) hold_m--;
`ifdef DAMAGE_HOLDOFF_EN
    if (supp) exp_dmg = 0;
`endif
    busy_cnt = 0;
    npulse   = 0;
    pulse_at = -1;
    got      = 0;
    @(negedge clk);
    player_x   = CW'(px);
    player_y   = CW'(py);
    frame_tick = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      frame_tick = (i == late);
      if (i == late && hold_m > 0) hold_m--;
      if (scramble && i == 2) begin
        player_x = CW'($urandom_range(1023));
        player_y = CW'($urandom_range(1023));
      end
      if (busy) busy_cnt++;
      if (slim_damage != 2'd0) begin
        npulse++;
        pulse_at = i;
        got      = int'(slim_damage);
      end
    end
    if (!supp && hits > 0) hold_m = HOLD;
    if (hits > 0) exp_hidx = first;
    check_eq({tag, " busy_cycles"}, busy_cnt, 2 * N + 1);
    check_eq({tag, " pulses"}, npulse, (exp_dmg != 0) ? 1 : 0);
    if (exp_dmg != 0) begin
      check_eq({tag, " damage"}, got, exp_dmg);
      check_eq({tag, " latency"}, pulse_at, 2 * N + 1);
    end
    check_eq({tag, " hit_idx"}, int'(hit_idx), exp_hidx);
  endtask

  task automatic random_slot(input int i, input int px, input int py);
    int x, y;
    if ($urandom_range(1) == 1) begin
      x = px + int'($urandom_range(80)) - 40;
      y = py + int'($urandom_range(80)) - 40;
      if (x < 0 || x > 1023) x = int'($urandom_range(1023));
      if (y < 0 || y > 1023) y = int'($urandom_range(1023));
    end else begin
      x = int'($urandom_range(1023));
      y = int'($urandom_range(1023));
    end
    set_slot(i, x, y, $urandom_range(3) != 0);
  endtask

  initial begin
    int px, py, busy_seen, pulse_seen;
    n_checks   = 0;
    n_fail     = 0;
    exp_hidx   = 0;
    hold_m     = 0;
    reset      = 1'b1;
    frame_tick = 1'b0;
    player_x   = '0;
    player_y   = '0;
    kill_all();
    #1;
    check_eq("rst damage", int'(slim_damage), 0);
    check_eq("rst busy", int'(busy), 0);
    check_eq("rst hit_idx", int'(hit_idx), 0);
    check_eq("rst slime_idx", int'(slime_idx), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    set_slot(2, 120, 110, 1'b1);
    run_scan("t1 single", 100, 100, -1, 1'b0);

    for (int i = 0; i < N; i++) set_slot(i, 100, 100, 1'b1);
    run_scan("t2 saturate", 100, 100, -1, 1'b0);

    kill_all();
    set_slot(0, 132, 100, 1'b1);
    run_scan("t3 edge miss", 100, 100, -1, 1'b0);
    set_slot(0, 131, 100, 1'b1);
    run_scan("t3 edge hit", 100, 100, -1, 1'b0);
    set_slot(0, 100, 68, 1'b1);
    run_scan("t3 y miss", 100, 100, -1, 1'b0);

    kill_all();
    set_slot(1, 5, 5, 1'b1);
    run_scan("t4 nowrap", 1020, 1020, -1, 1'b0);
    set_slot(1, 1020, 1020, 1'b0);
    run_scan("t4 dead", 1020, 1020, -1, 1'b0);

    // Abort a hitting scan with reset mid-flight.
    kill_all();
    set_slot(3, 500, 500, 1'b1);
    @(negedge clk);
    player_x   = CW'(500);
    player_y   = CW'(500);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("t5 rst damage", int'(slim_damage), 0);
    check_eq("t5 rst busy", int'(busy), 0);
    check_eq("t5 rst hit_idx", int'(hit_idx), 0);
    check_eq("t5 rst slime_idx", int'(slime_idx), 0);
    exp_hidx = 0;
    hold_m   = 0;
    @(negedge clk);
    reset      = 1'b0;
    busy_seen  = 0;
    pulse_seen = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
      if (slim_damage != 2'd0) pulse_seen++;
    end
    check_eq("t5 abort busy", busy_seen, 0);
    check_eq("t5 abort pulse", pulse_seen, 0);

    run_scan("t5 ignore tick", 510, 490, 3, 1'b0);
    run_scan("t5 snapshot", 500, 500, -1, 1'b1);

    for (int k = 0; k < 40; k++) begin
      px = int'($urandom_range(1023));
      py = int'($urandom_range(1023));
      for (int i = 0; i < N; i++) random_slot(i, px, py);
      run_scan("rand", px, py,
               ($urandom_range(1) == 1) ? int'($urandom_range(6)) : -1,
               $urandom_range(1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
